// File: rtl/vec_alu_seq.sv
// Sequencer for the replicated vec_alu lanes: primes, runs for BEATS cycles, merges lane chunks.
// Optional protocol checker on alu_done enabled by defining VEC_ALU_SEQ_CHECK_EN.
module vec_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4,
  parameter int NB_LANES   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [5:0]                       req_opcode,
  input  logic [2:0]                       req_vsew,
  input  logic [VLEN-1:0]                  req_vs1,
  input  logic [VLEN-1:0]                  req_vs2,
  output logic                             alu_run,
  output logic [5:0]                       alu_opcode,
  output logic [2:0]                       alu_vsew,
  output logic [VLEN-1:0]                  alu_vs1,
  output logic [VLEN-1:0]                  alu_vs2,
  input  logic [(1<<NB_LANES)*VLEN-1:0]    alu_vd,
  input  logic [(1<<NB_LANES)*10-1:0]      alu_reg_index,
  input  logic [(1<<NB_LANES)-1:0]         alu_done,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [VLEN-1:0]                  resp_vd,
  output logic                             resp_err
);

  localparam int unsigned W     = 1 << LANE_WIDTH;
  localparam int unsigned NL    = 1 << NB_LANES;
  localparam int unsigned BEATS = VLEN >> (LANE_WIDTH + NB_LANES);
  localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [VLEN-1:0] CHUNK_MASK = {{(VLEN-W){1'b0}}, {W{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [VLEN-1:0] result;
  logic [VLEN-1:0] merged;
  logic [VLEN-1:0] lane_mask;
  logic            err_q;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign alu_run    = (state == S_RUN);
  assign resp_vd    = result;

  // Shifting the chunk mask left drops bits past VLEN, so oversized offsets clip instead of
  // wrapping; lanes are folded in ascending order so the highest lane wins on overlap.
  always_comb begin
    merged    = result;
    lane_mask = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      lane_mask = CHUNK_MASK << alu_reg_index[i*10 +: 10];
      merged    = (merged & ~lane_mask) | (alu_vd[i*VLEN +: VLEN] & lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      result     <= '0;
      err_q      <= 1'b0;
      alu_opcode <= '0;
      alu_vsew   <= '0;
      alu_vs1    <= '0;
      alu_vs2    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          alu_opcode <= req_opcode;
          alu_vsew   <= req_vsew;
          alu_vs1    <= req_vs1;
          alu_vs2    <= req_vs2;
          result     <= '0;
          cnt        <= '0;
          if (req_vsew > 3'd3) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            state <= S_PRIME;
          end
        end
        S_PRIME: state <= S_RUN;
        S_RUN: begin
          result <= merged;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= S_RESP;
        end
        S_RESP: if (resp_ready) begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VEC_ALU_SEQ_CHECK_EN
  logic chk_fault;
  logic chk_final;

  // The all-done check is also applied combinationally in the first RESP cycle so a response
  // consumed immediately still carries the fault.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      chk_fault <= 1'b0;
      chk_final <= 1'b0;
    end else if (state == S_RUN) begin
      chk_final <= (cnt == LAST);
      if (((cnt != LAST) && (|alu_done)) || ((|alu_done) && !(&alu_done)))
        chk_fault <= 1'b1;
    end else if (state == S_RESP && chk_final) begin
      chk_final <= 1'b0;
      if (!(&alu_done)) chk_fault <= 1'b1;
    end
  end

  assign resp_err = err_q | (resp_valid & (chk_fault | (chk_final & ~(&alu_done))));
`else
  logic unused_done;
  assign unused_done = ^alu_done;
  assign resp_err    = err_q;
`endif

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq with two behavioural lanes and a bit-level merge model.
module tb_vec_alu_seq;

  localparam int VLEN  = 128;
  localparam int W     = 16;
  localparam int NL    = 2;
  localparam int BEATS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [5:0]        req_opcode = '0;
  logic [2:0]        req_vsew = '0;
  logic [VLEN-1:0]   req_vs1 = '0;
  logic [VLEN-1:0]   req_vs2 = '0;
  logic              alu_run;
  logic [5:0]        alu_opcode;
  logic [2:0]        alu_vsew;
  logic [VLEN-1:0]   alu_vs1;
  logic [VLEN-1:0]   alu_vs2;
  logic [NL*VLEN-1:0] alu_vd;
  logic [NL*10-1:0]  alu_reg_index;
  logic [NL-1:0]     alu_done;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [VLEN-1:0]   resp_vd;
  logic              resp_err;

  int n_cmp = 0;
  int n_err = 0;
  int lb = 0;     // lane beat counter, restarts whenever run is low
  int mode = 0;   // 0: tiled chunks; 1: overlapping and clipped chunks

  always #5 clk = ~clk;

  vec_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(4), .NB_LANES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode), .req_vsew(req_vsew),
    .req_vs1(req_vs1), .req_vs2(req_vs2),
    .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vsew(alu_vsew), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2),
    .alu_vd(alu_vd), .alu_reg_index(alu_reg_index), .alu_done(alu_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vd(resp_vd), .resp_err(resp_err)
  );

  function automatic int lane_idx(int m, int b, int i);
    if (m == 0) return (b * NL + i) * W;
    if (i == 1 && b == 3) return 120;
    return b * 32;
  endfunction

  // Lane bus carries the true xor only inside its own chunk, so wrong-lane or wrong-offset picks show up.
  function automatic logic [VLEN-1:0] lane_vd(int m, int i, int idx, logic [VLEN-1:0] x);
    logic [VLEN-1:0] v;
    if (m == 1) begin
      if (i == 0) return x;
      return (idx == 120) ? x : ~x;
    end
    for (int k = 0; k < VLEN; k++) v[k] = (k >= idx && k < idx + W) ? x[k] : ~x[k];
    return v;
  endfunction

  function automatic logic [VLEN-1:0] model_vd(int m, logic [VLEN-1:0] a, logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    logic [VLEN-1:0] v;
    int idx;
    r = '0;
    for (int bt = 0; bt < BEATS; bt++)
      for (int i = 0; i < NL; i++) begin
        idx = lane_idx(m, bt, i);
        v = lane_vd(m, i, idx, a ^ b);
        for (int k = 0; k < W; k++)
          if (idx + k < VLEN) r[idx + k] = v[idx + k];
      end
    return r;
  endfunction

  always @(posedge clk) lb <= alu_run ? lb + 1 : 0;

  always_comb begin
    alu_vd        = '0;
    alu_reg_index = '0;
    for (int i = 0; i < NL; i++) begin
      alu_reg_index[i*10 +: 10] = 10'(lane_idx(mode, lb, i));
      alu_vd[i*VLEN +: VLEN]    = lane_vd(mode, i, lane_idx(mode, lb, i), alu_vs1 ^ alu_vs2);
    end
    alu_done = (lb == BEATS) ? '1 : '0;
  end

  function automatic logic [VLEN-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request into an idle DUT and waits (bounded) for resp_valid.
  task automatic run_op(input int m, input logic [5:0] op, input logic [2:0] sew,
                        input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                        output int runs, output int lat, output logic [5:0] seen_op, output logic [2:0] seen_sew);
    mode = m; req_opcode = op; req_vsew = sew; req_vs1 = a; req_vs2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    runs = 0; lat = 1; seen_op = '0; seen_sew = '0;
    while (!resp_valid && lat < 40) begin
      if (alu_run) begin runs++; seen_op = alu_opcode; seen_sew = alu_vsew; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (alu_run !== 1'b0) begin n_err++; $display("FAIL reset_alu_run got=%b exp=0", alu_run); end
    n_cmp++; if (resp_vd !== '0) begin n_err++; $display("FAIL reset_resp_vd got=%h exp=0", resp_vd); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    n_cmp++; if ({alu_opcode, alu_vsew, alu_vs1, alu_vs2} !== '0) begin n_err++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_opcode, alu_vsew, alu_vs1}); end
  endtask

  task automatic test_basic();
    logic [VLEN-1:0] a, b, exp;
    logic [5:0] sop;
    logic [2:0] ssew;
    int runs, lat;
    a = 128'habcdabcdbeefbeef1234567887654321;
    b = 128'h8765432112345678beefbeefabcdabcd;
    exp = model_vd(0, a, b);
    for (int s = 0; s < 4; s++) begin
      run_op(0, 6'h0b, 3'(s), a, b, runs, lat, sop, ssew);
      n_cmp++; if (runs !== 4) begin n_err++; $display("FAIL basic_run_cycles sew=%0d got=%0d exp=4", s, runs); end
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL basic_latency sew=%0d got=%0d exp=6", s, lat); end
      n_cmp++; if (resp_vd !== exp) begin n_err++; $display("FAIL basic_vd sew=%0d got=%h exp=%h", s, resp_vd, exp); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL basic_err sew=%0d got=%b exp=0", s, resp_err); end
      n_cmp++; if (ssew !== 3'(s) || sop !== 6'h0b) begin n_err++; $display("FAIL basic_fwd sew=%0d got=%h/%h exp=%h/0b", s, ssew, sop, s); end
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL basic_consume got=%b%b exp=01", resp_valid, req_ready); end
    end
  endtask

  task automatic test_illegal_vsew();
    mode = 0; req_vsew = 3'b101; req_opcode = 6'h11; req_vs1 = rnd_vec(); req_vs2 = rnd_vec(); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL illegal_resp_valid got=%b exp=1", resp_valid); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL illegal_resp_err got=%b exp=1", resp_err); end
    n_cmp++; if (resp_vd !== '0) begin n_err++; $display("FAIL illegal_resp_vd got=%h exp=0", resp_vd); end
    n_cmp++; if (alu_run !== 1'b0) begin n_err++; $display("FAIL illegal_run got=%b exp=0", alu_run); end
    @(posedge clk); #1;
    n_cmp++; if ({resp_valid, resp_err, alu_run, req_ready} !== 4'b0001) begin n_err++; $display("FAIL illegal_after got=%b exp=0001", {resp_valid, resp_err, alu_run, req_ready}); end
  endtask

  task automatic test_backpressure();
    logic [VLEN-1:0] a1, b1, a2, b2, e1, e2;
    logic [5:0] sop;
    logic [2:0] ssew;
    int runs, lat;
    a1 = rnd_vec(); b1 = rnd_vec(); a2 = rnd_vec(); b2 = rnd_vec();
    e1 = model_vd(0, a1, b1); e2 = model_vd(0, a2, b2);
    resp_ready = 1'b0;
    run_op(0, 6'h02, 3'd1, a1, b1, runs, lat, sop, ssew);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    req_opcode = 6'h03; req_vsew = 3'd2; req_vs1 = a2; req_vs2 = b2; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (resp_valid !== 1'b1 || resp_vd !== e1) begin n_err++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, resp_valid, resp_vd, e1); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready c=%0d got=%b exp=0", c, req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b%b exp=01", resp_valid, req_ready); end
    run_op(0, 6'h03, 3'd2, a2, b2, runs, lat, sop, ssew);
    n_cmp++; if (resp_vd !== e2 || lat !== 6) begin n_err++; $display("FAIL bp_second got=%h/%0d exp=%h/6", resp_vd, lat, e2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    logic [VLEN-1:0] a, b, e;
    logic [5:0] sop;
    logic [2:0] ssew;
    int runs, lat, seen;
    mode = 0; req_opcode = 6'h05; req_vsew = 3'd0; req_vs1 = rnd_vec(); req_vs2 = rnd_vec(); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (alu_run !== 1'b1) begin n_err++; $display("FAIL midrst_run_started got=%b exp=1", alu_run); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if ({alu_run, resp_valid, req_ready} !== 3'b001) begin n_err++; $display("FAIL midrst_state got=%b exp=001", {alu_run, resp_valid, req_ready}); end
    n_cmp++; if (resp_vd !== '0) begin n_err++; $display("FAIL midrst_vd got=%h exp=0", resp_vd); end
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
    a = rnd_vec(); b = rnd_vec(); e = model_vd(0, a, b);
    run_op(0, 6'h06, 3'd3, a, b, runs, lat, sop, ssew);
    n_cmp++; if (resp_vd !== e || runs !== 4 || lat !== 6) begin n_err++; $display("FAIL midrst_next got=%h/%0d/%0d exp=%h/4/6", resp_vd, runs, lat, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_overlap_clip();
    logic [VLEN-1:0] a, b, e;
    logic [5:0] sop;
    logic [2:0] ssew;
    int runs, lat;
    for (int n = 0; n < 3; n++) begin
      a = rnd_vec(); b = rnd_vec(); e = model_vd(1, a, b);
      run_op(1, 6'h09, 3'd0, a, b, runs, lat, sop, ssew);
      n_cmp++; if (resp_vd !== e) begin n_err++; $display("FAIL overlap_clip_vd n=%0d got=%h exp=%h", n, resp_vd, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [VLEN-1:0] a, b, e;
    logic [5:0] op, sop;
    logic [2:0] sew, ssew;
    int runs, lat, m;
    for (int n = 0; n < 8; n++) begin
      a = rnd_vec(); b = rnd_vec(); m = int'($urandom_range(1, 0));
      op = 6'($urandom); sew = 3'($urandom_range(3, 0));
      e = model_vd(m, a, b);
      run_op(m, op, sew, a, b, runs, lat, sop, ssew);
      n_cmp++; if (resp_vd !== e || resp_err !== 1'b0) begin n_err++; $display("FAIL random_vd n=%0d got=%h/%b exp=%h/0", n, resp_vd, resp_err, e); end
      n_cmp++; if (runs !== 4 || lat !== 6 || sop !== op || ssew !== sew) begin n_err++; $display("FAIL random_timing n=%0d got=%0d/%0d/%h/%h exp=4/6/%h/%h", n, runs, lat, sop, ssew, op, sew); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] a[3];
    logic [VLEN-1:0] b[3];
    int acc[3];
    int nacc, nresp;
    mode = 0; resp_ready = 1'b1; nacc = 0; nresp = 0;
    for (int k = 0; k < 3; k++) begin a[k] = rnd_vec(); b[k] = rnd_vec(); acc[k] = 0; end
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (resp_valid) begin
        n_cmp++; if (nresp >= 3 || resp_vd !== model_vd(0, a[nresp % 3], b[nresp % 3])) begin n_err++; $display("FAIL b2b_vd r=%0d got=%h", nresp, resp_vd); end
        nresp++;
      end
      if (req_ready && nacc < 3) begin
        req_opcode = 6'h01; req_vsew = 3'd0; req_vs1 = a[nacc]; req_vs2 = b[nacc]; req_valid = 1'b1;
        acc[nacc] = cyc; nacc++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_cmp++; if (nresp !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", nresp); end
    n_cmp++; if (acc[1] - acc[0] !== 7 || acc[2] - acc[1] !== 7) begin n_err++; $display("FAIL b2b_period got=%0d,%0d exp=7,7", acc[1] - acc[0], acc[2] - acc[1]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_illegal_vsew();
    test_backpressure();
    test_reset_mid_op();
    test_overlap_clip();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
